cpu_rf_wb: RTL

Writeback stage that drives the CPU register file write port (wrt_sel/wrt_data/wrt_en).
- Accepts results from two producers, the ALU and the memory load path, over valid/ready handshakes.
- Buffers results in a small in-order FIFO and retires one register write per cycle.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards.
- Filters writes to the zero register R0 so that R0 stays zero.

---
 rtl/cpu_rf_wb_if.sv | 45 ++++
 rtl/cpu_rf_wb.sv | 134 +++++++++++++
 2 files changed

// File: rtl/cpu_rf_wb_if.sv
// Writeback-stage bus: two result producers, decode issue, register-file write port and status.
// The master side drives results and issues; the slave side is the writeback stage.
interface cpu_rf_wb_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RN = 16
);
  localparam int unsigned SW = $clog2(RN);

  logic          alu_vld;
  logic          alu_rdy;
  logic [SW-1:0] alu_sel;
  logic [DW-1:0] alu_data;

  logic          mem_vld;
  logic          mem_rdy;
  logic [SW-1:0] mem_sel;
  logic [DW-1:0] mem_data;

  logic          iss_vld;
  logic [SW-1:0] iss_sel;
  logic [RN-1:0] busy;

  logic          wrt_en;
  logic [SW-1:0] wrt_sel;
  logic [DW-1:0] wrt_data;

  logic          empty;
  logic          err;

  modport master (
    output alu_vld, alu_sel, alu_data,
    output mem_vld, mem_sel, mem_data,
    output iss_vld, iss_sel,
    input  alu_rdy, mem_rdy, busy,
    input  wrt_en, wrt_sel, wrt_data, empty, err
  );

  modport slave (
    input  alu_vld, alu_sel, alu_data,
    input  mem_vld, mem_sel, mem_data,
    input  iss_vld, iss_sel,
    output alu_rdy, mem_rdy, busy,
    output wrt_en, wrt_sel, wrt_data, empty, err
  );
endinterface

// File: rtl/cpu_rf_wb.sv
// CPU writeback stage: arbitrates ALU/load results into an in-order FIFO, retires one
// register write per cycle, tracks pending writes per register and drops writes to R0.
module cpu_rf_wb #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned RN    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  cpu_rf_wb_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(RN);

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
  } wb_entry_t;

  wb_entry_t     fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic [RN-1:0] busy_q;
  logic [RN-1:0] busy_nxt;
  logic          wrt_en_q;
  logic [SW-1:0] wrt_sel_q;
  logic [DW-1:0] wrt_data_q;
  logic          err_q;

  logic          full;
  logic          pop;
  logic          push_mem;
  logic          push_alu;
  logic          push;
  wb_entry_t     push_entry;
  wb_entry_t     head;
  logic          head_r0;

  // Full is judged on the current count only, so a same-cycle pop never frees a slot
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = (count_q != '0);
  assign push_mem = bus.mem_vld & ~full;
  assign push_alu = bus.alu_vld & ~full & ~bus.mem_vld;
  assign push     = push_mem | push_alu;
  assign head     = fifo_q[rd_ptr_q];
  assign head_r0  = (head.sel == '0);

  // Memory producer has fixed priority over the ALU
  always_comb begin
    push_entry = '0;
    if (push_mem) begin
      push_entry.sel  = bus.mem_sel;
      push_entry.data = bus.mem_data;
    end else begin
      push_entry.sel  = bus.alu_sel;
      push_entry.data = bus.alu_data;
    end
  end

  // Result storage needs no reset: validity is tracked by the count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A new issue to a register beats the retire of its older write in the same cycle
  always_comb begin
    busy_nxt = busy_q;
    if (pop && !head_r0) begin
      busy_nxt[head.sel] = 1'b0;
    end
    if (bus.iss_vld && (bus.iss_sel != '0)) begin
      busy_nxt[bus.iss_sel] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Register-file write port; sel/data hold their last value while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      wrt_en_q   <= 1'b0;
      wrt_sel_q  <= '0;
      wrt_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q   <= busy_nxt;
      wrt_en_q <= pop & ~head_r0;
      if (pop && !head_r0) begin
        wrt_sel_q  <= head.sel;
        wrt_data_q <= head.data;
      end
      if (pop && head_r0 && (head.data != '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.mem_rdy  = ~full;
  assign bus.alu_rdy  = ~full & ~bus.mem_vld;
  assign bus.busy     = busy_q;
  assign bus.wrt_en   = wrt_en_q;
  assign bus.wrt_sel  = wrt_sel_q;
  assign bus.wrt_data = wrt_data_q;
  assign bus.empty    = (count_q == '0) & ~wrt_en_q;
  assign bus.err      = err_q;

endmodule
